// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the two-master sp_ram front end.
package sp_ram_arb_pkg;

    localparam int PORT_INSTR     = 0;
    localparam int PORT_DATA      = 1;
    localparam int NUM_PORTS      = 2;
    localparam int MAX_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [3:0]                be;
        logic [31:0]               wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP0 = 2'd1,
        RSP1 = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/sp_ram_arb_if.sv
// Per-master req/gnt/rvalid bus; index 0 = instruction port, index 1 = data port.
interface sp_ram_arb_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [1:0]                 m_req_i;
    logic [1:0][ADDR_WIDTH-1:0] m_addr_i;
    logic [1:0]                 m_we_i;
    logic [1:0][3:0]            m_be_i;
    logic [1:0][31:0]           m_wdata_i;
    logic [1:0]                 m_gnt_o;
    logic [1:0]                 m_rvalid_o;
    logic [1:0][31:0]           m_rdata_o;
    logic [1:0]                 m_err_o;

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o
    );

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o
    );
endinterface

// File: rtl/sp_ram_arb_sel.sv
// Grant selection: fixed priority (data over instr) or, with SP_RAM_ARB_RR_EN, round-robin.
module sp_ram_arb_sel
    import sp_ram_arb_pkg::*;
(
`ifdef SP_RAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef SP_RAM_ARB_RR_EN
    // Last granted port; reset value 0 lets port 1 win the first contention.
    logic last_r;

    // Contention goes to the port that was not granted last.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_r ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Pointer moves only on cycles that actually grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b0;
        end else if (|gnt) begin
            last_r <= gnt[PORT_DATA];
        end else begin
            last_r <= last_r;
        end
    end
`else
    // Fixed priority: the data port always wins; instr may starve.
    always_comb begin
        gnt = 2'b00;
        if (req[PORT_DATA]) begin
            gnt = 2'b10;
        end else if (req[PORT_INSTR]) begin
            gnt = 2'b01;
        end else begin
            gnt = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/sp_ram_arb.sv
// Two-master front end for a single-port RAM with 1-cycle read latency.
// Define SP_RAM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module sp_ram_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter int          NUM_BYTES  = 32768,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sp_ram_arb_if.slave           bus,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    logic [1:0]       gnt_s;
    mem_req_t         sel_req_s;
    logic             in_range_s;
    logic             ram_en_s;
    rsp_state_e       rsp_state_r;
    rsp_state_e       rsp_next_s;
    logic             rd_pend_r;
    logic [1:0]       rvalid_s;
    logic [1:0][31:0] rdata_r;
    logic [1:0]       err_r;

    sp_ram_arb_sel u_sel (
`ifdef SP_RAM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req   (bus.m_req_i),
        .gnt   (gnt_s)
    );

    assign bus.m_gnt_o = gnt_s;

    // Mux the granted master's request onto a single bundle.
    always_comb begin
        sel_req_s = '0;
        if (gnt_s[PORT_DATA]) begin
            sel_req_s.addr  = MAX_ADDR_WIDTH'(bus.m_addr_i[PORT_DATA]);
            sel_req_s.we    = bus.m_we_i[PORT_DATA];
            sel_req_s.be    = bus.m_be_i[PORT_DATA];
            sel_req_s.wdata = bus.m_wdata_i[PORT_DATA];
        end else if (gnt_s[PORT_INSTR]) begin
            sel_req_s.addr  = MAX_ADDR_WIDTH'(bus.m_addr_i[PORT_INSTR]);
            sel_req_s.we    = bus.m_we_i[PORT_INSTR];
            sel_req_s.be    = bus.m_be_i[PORT_INSTR];
            sel_req_s.wdata = bus.m_wdata_i[PORT_INSTR];
        end else begin
            sel_req_s = '0;
        end
    end

    assign in_range_s = (sel_req_s.addr < MAX_ADDR_WIDTH'(NUM_BYTES));
    assign ram_en_s   = (|gnt_s) & in_range_s;

    // RAM side is driven only for in-range grants; otherwise everything sits at 0.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_wdata_o = 32'h0;
        if (ram_en_s) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = sel_req_s.addr[ADDR_WIDTH-1:0];
            ram_we_o    = sel_req_s.we;
            ram_be_o    = sel_req_s.be;
            ram_wdata_o = sel_req_s.wdata;
        end else begin
            ram_en_o    = 1'b0;
        end
    end

    // Response owner for the next cycle follows this cycle's grant.
    always_comb begin
        rsp_next_s = IDLE;
        if (gnt_s[PORT_DATA]) begin
            rsp_next_s = RSP1;
        end else if (gnt_s[PORT_INSTR]) begin
            rsp_next_s = RSP0;
        end else begin
            rsp_next_s = IDLE;
        end
    end

    // Response state and whether its data must come straight from the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_state_r <= IDLE;
            rd_pend_r   <= 1'b0;
        end else begin
            rsp_state_r <= rsp_next_s;
            rd_pend_r   <= ram_en_s & ~sel_req_s.we;
        end
    end

    assign rvalid_s[PORT_INSTR] = (rsp_state_r == RSP0);
    assign rvalid_s[PORT_DATA]  = (rsp_state_r == RSP1);
    assign bus.m_rvalid_o       = rvalid_s;
    assign bus.m_err_o          = err_r;

    // Error/write results are known at grant time; read data is captured as it streams out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
            err_r   <= 2'b00;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt_s[p]) begin
                    if (!in_range_s) begin
                        err_r[p]   <= 1'b1;
                        rdata_r[p] <= ERR_RDATA;
                    end else if (sel_req_s.we) begin
                        err_r[p]   <= 1'b0;
                        rdata_r[p] <= 32'h0;
                    end else begin
                        err_r[p]   <= 1'b0;
                    end
                end else if (rvalid_s[p] && rd_pend_r) begin
                    rdata_r[p] <= ram_rdata_i;
                end else begin
                    rdata_r[p] <= rdata_r[p];
                end
            end
        end
    end

    // Live RAM data during an in-range read response, held value otherwise.
    always_comb begin
        bus.m_rdata_o = rdata_r;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rvalid_s[p] && rd_pend_r) begin
                bus.m_rdata_o[p] = ram_rdata_i;
            end else begin
                bus.m_rdata_o[p] = rdata_r[p];
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_arb.sv
// Directed bench for sp_ram_arb with a behavioural 1 KiB sp_ram; handles both arbitration builds.
module tb_sp_ram_arb;

    logic        clk;
    logic        rst_n;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;
    int n1    = 0;
    int n0    = 0;
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;

    sp_ram_arb_if #(.ADDR_WIDTH(16)) bus ();

    sp_ram_arb #(
        .ADDR_WIDTH (16),
        .NUM_BYTES  (1024),
        .ERR_RDATA  (32'hDEAD_BEEF)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sp_ram: byte-enabled writes, registered reads.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[9:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic [15:0] addr,
                         input logic we, input logic [3:0] be, input logic [31:0] wdata);
        bus.m_req_i[p]   = req;
        bus.m_addr_i[p]  = addr;
        bus.m_we_i[p]    = we;
        bus.m_be_i[p]    = be;
        bus.m_wdata_i[p] = wdata;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.m_req_i   = 2'b00;
        bus.m_addr_i  = '0;
        bus.m_we_i    = 2'b00;
        bus.m_be_i    = '0;
        bus.m_wdata_i = '0;
        ram_rdata     = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rvalid", 32'(bus.m_rvalid_o), 32'h0);
        check("rst_err",    32'(bus.m_err_o),    32'h0);
        check("rst_rdata0", bus.m_rdata_o[0],    32'h0);
        check("rst_rdata1", bus.m_rdata_o[1],    32'h0);
        check("rst_gnt",    32'(bus.m_gnt_o),    32'h0);
        check("rst_ram_en", 32'(ram_en),         32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 1 write then port 0 read of the same word
        @(negedge clk);
        drive(1, 1'b1, 16'h0100, 1'b1, 4'hF, 32'hCAFE_F00D);
        #1;
        check("t1_wr_gnt",   32'(bus.m_gnt_o), 32'h2);
        check("t1_wr_en",    32'(ram_en),      32'h1);
        check("t1_wr_addr",  32'(ram_addr),    32'h100);
        check("t1_wr_we",    32'(ram_we),      32'h1);
        check("t1_wr_wdata", ram_wdata,        32'hCAFE_F00D);
        @(negedge clk);
        check("t1_wr_rvalid", 32'(bus.m_rvalid_o), 32'h2);
        check("t1_wr_rdata",  bus.m_rdata_o[1],    32'h0);
        check("t1_wr_err",    32'(bus.m_err_o[1]), 32'h0);
        drive(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        drive(0, 1'b1, 16'h0100, 1'b0, 4'hF, 32'h0);
        #1;
        check("t1_rd_gnt", 32'(bus.m_gnt_o), 32'h1);
        check("t1_rd_we",  32'(ram_we),      32'h0);
        @(negedge clk);
        check("t1_rd_rvalid", 32'(bus.m_rvalid_o), 32'h1);
        check("t1_rd_rdata",  bus.m_rdata_o[0],    32'hCAFE_F00D);
        check("t1_rd_err",    32'(bus.m_err_o[0]), 32'h0);
        drive(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);

        // Out-of-range read
        @(negedge clk);
        drive(0, 1'b1, 16'h0400, 1'b0, 4'hF, 32'h0);
        #1;
        check("t3_gnt",    32'(bus.m_gnt_o), 32'h1);
        check("t3_ram_en", 32'(ram_en),      32'h0);
        check("t3_addr",   32'(ram_addr),    32'h0);
        @(negedge clk);
        check("t3_rvalid", 32'(bus.m_rvalid_o), 32'h1);
        check("t3_err",    32'(bus.m_err_o[0]), 32'h1);
        check("t3_rdata",  bus.m_rdata_o[0],    32'hDEAD_BEEF);
        drive(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("t3_idle_rvalid", 32'(bus.m_rvalid_o), 32'h0);
        check("t3_hold_rdata",  bus.m_rdata_o[0],    32'hDEAD_BEEF);
        check("t3_hold_err",    32'(bus.m_err_o[0]), 32'h1);

        // Byte-lane write
        drive(1, 1'b1, 16'h0010, 1'b1, 4'hF, 32'h1122_3344);
        @(negedge clk);
        drive(1, 1'b1, 16'h0010, 1'b1, 4'b0010, 32'h0000_AB00);
        @(negedge clk);
        drive(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        drive(0, 1'b1, 16'h0010, 1'b0, 4'hF, 32'h0);
        #1;
        check("t4_gnt", 32'(bus.m_gnt_o), 32'h1);
        @(negedge clk);
        check("t4_rvalid", 32'(bus.m_rvalid_o), 32'h1);
        check("t4_rdata0", bus.m_rdata_o[0],    32'h1122_AB44);
        check("t4_rdata1", bus.m_rdata_o[1],    32'h0);
        check("t4_err1",   32'(bus.m_err_o[1]), 32'h0);
        check("t4_err0",   32'(bus.m_err_o[0]), 32'h0);

        // Continuous contention for 8 cycles
        drive(0, 1'b1, 16'h0100, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 16'h0010, 1'b0, 4'hF, 32'h0);
        prev_gnt = 2'b00;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef SP_RAM_ARB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b10;
`endif
            check("t2_gnt", 32'(bus.m_gnt_o), 32'(exp_gnt));
            if (i > 0) check("t2_rvalid", 32'(bus.m_rvalid_o), 32'(prev_gnt));
            if (bus.m_gnt_o[1]) n1++;
            if (bus.m_gnt_o[0]) n0++;
            prev_gnt = exp_gnt;
            @(negedge clk);
        end
        check("t2_last_rvalid", 32'(bus.m_rvalid_o), 32'(prev_gnt));
        check("t2_rdata1",      bus.m_rdata_o[1],    32'h1122_AB44);
`ifdef SP_RAM_ARB_RR_EN
        check("t2_n1",     32'(n1),          32'd4);
        check("t2_n0",     32'(n0),          32'd4);
        check("t2_rdata0", bus.m_rdata_o[0], 32'hCAFE_F00D);
`else
        check("t2_n1", 32'(n1), 32'd8);
        check("t2_n0", 32'(n0), 32'd0);
`endif
        drive(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);

        // Port 1 withdraws before its grant edge
        @(negedge clk);
        drive(0, 1'b1, 16'h0100, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 16'h0010, 1'b0, 4'hF, 32'h0);
        #2;
        drive(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        #1;
        check("t6_gnt", 32'(bus.m_gnt_o), 32'h1);
        @(negedge clk);
        check("t6_rvalid", 32'(bus.m_rvalid_o), 32'h1);
        drive(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);

        // Async reset right after a grant drops the response
        @(negedge clk);
        drive(1, 1'b1, 16'h0010, 1'b0, 4'hF, 32'h0);
        #1;
        check("t5_gnt", 32'(bus.m_gnt_o), 32'h2);
        @(posedge clk);
        #2;
        drive(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_rvalid", 32'(bus.m_rvalid_o), 32'h0);
        check("t5_rst_rdata1", bus.m_rdata_o[1],    32'h0);
        check("t5_rst_err",    32'(bus.m_err_o),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_rvalid", 32'(bus.m_rvalid_o), 32'h0);
        drive(0, 1'b1, 16'h0100, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 16'h0010, 1'b0, 4'hF, 32'h0);
        #1;
        check("t5_first_gnt", 32'(bus.m_gnt_o), 32'h2);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        check("t5_first_rvalid", 32'(bus.m_rvalid_o), 32'h2);
        check("t5_first_rdata1", bus.m_rdata_o[1],    32'h1122_AB44);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
